// File: rtl/serial_divisibility_by_n_using_fsm.sv
// serial_divisibility_by_n_using_fsm: MSB-first remainder modulo DIVISOR, BITS_PER_CYCLE bits per accepted beat
// Optional macro SERIAL_DIV_BIT_COUNT_EN adds a saturating 16-bit bit_count output.
module serial_divisibility_by_n_using_fsm #(
  parameter int DIVISOR        = 5,
  parameter int BITS_PER_CYCLE = 1,
  parameter int RW             = $clog2(DIVISOR)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_start,
  input  logic [BITS_PER_CYCLE-1:0] new_bits,
  output logic                      out_valid,
  output logic                      div_by_n,
  output logic [RW-1:0]             remainder
`ifdef SERIAL_DIV_BIT_COUNT_EN
  ,
  output logic [15:0]               bit_count
`endif
);
  localparam logic [RW:0] DV = DIVISOR[RW:0];
  logic [RW-1:0] t [BITS_PER_CYCLE+1];
  logic [RW:0]   w [BITS_PER_CYCLE];
  logic [RW-1:0] rem_q, rem_d;
  logic          div_q, valid_q;
  assign t[0] = in_start ? '0 : rem_q;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    assign w[i]   = {t[i], new_bits[BITS_PER_CYCLE-1-i]};
    assign t[i+1] = w[i] >= DV ? RW'(w[i] - DV) : w[i][RW-1:0];
  end
  assign rem_d     = t[BITS_PER_CYCLE];
  assign remainder = rem_q;
  assign div_by_n  = div_q;
  assign out_valid = valid_q;
  // remainder and its zero flag move together on accepted beats; valid pulses one cycle after each beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem_q   <= '0;
      div_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        rem_q <= rem_d;
        div_q <= rem_d == '0;
      end
    end
`ifdef SERIAL_DIV_BIT_COUNT_EN
  localparam logic [15:0] BC = 16'(BITS_PER_CYCLE);
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d     = in_start ? BC : (cnt_q > 16'hFFFF - BC ? 16'hFFFF : cnt_q + BC);
  assign bit_count = cnt_q;
  // bits absorbed into the current number, restarting on in_start and saturating at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (in_valid) cnt_q <= cnt_d;
`endif
endmodule
